// File: rtl/tnew_m_pkg.sv
// rtl/tnew_m_pkg.sv - shared opcode, funct, ALU and access-width constants for the M-stage decode
package tnew_m_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ERET  = 6'h18;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // COP0 sub-operation lives in the rs field
  localparam logic [4:0] RS_MF    = 5'h00;
  localparam logic [4:0] RS_MT    = 5'h04;
  localparam logic [4:0] RS_CO    = 5'h10;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_NOR  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_LUI  = 5'd11;

  typedef enum logic [1:0] {
    HBW_W = 2'd0,
    HBW_H = 2'd1,
    HBW_B = 2'd2
  } hbw_e;

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

endpackage

// File: rtl/tnew_m_instr_ctrl_dec.sv
// rtl/tnew_m_instr_ctrl_dec.sv - combinational instruction-to-control decoder
module instr_ctrl_dec
  import tnew_m_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        tiao,
  input  logic        stall,
  output logic        regDst,
  output logic        reg31,
  output logic        siExt,
  output logic        shift2,
  output logic        regWrite,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic        regIn,
  output logic        memWrite,
  output logic        branch,
  output logic        j,
  output logic        jr,
  output logic        jl,
  output logic        dmExt,
  output logic        eret,
  output logic        mtc,
  output logic        mfc,
  output logic [4:0]  ALUOP,
  output logic [1:0]  hbw
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_rs;
  logic       w_ralu;
  logic       w_reg_write;
  logic       w_mem_write;
  logic       w_unused;

  assign w_op     = instr[31:26];
  assign w_funct  = instr[5:0];
  assign w_rs     = instr[25:21];
  assign w_unused = ^{instr[20:6], tiao};

  always_comb begin
    regDst      = 1'b0;
    reg31       = 1'b0;
    siExt       = 1'b0;
    shift2      = 1'b0;
    ALUSrc1     = 1'b0;
    ALUSrc2     = 1'b0;
    regIn       = 1'b0;
    branch      = 1'b0;
    j           = 1'b0;
    jr          = 1'b0;
    jl          = 1'b0;
    dmExt       = 1'b0;
    eret        = 1'b0;
    mtc         = 1'b0;
    mfc         = 1'b0;
    ALUOP       = ALU_ADD;
    hbw         = HBW_W;
    w_ralu      = 1'b0;
    w_reg_write = 1'b0;
    w_mem_write = 1'b0;

    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADDU: begin w_ralu = 1'b1; ALUOP = ALU_ADD;  end
          FN_SUBU: begin w_ralu = 1'b1; ALUOP = ALU_SUB;  end
          FN_AND:  begin w_ralu = 1'b1; ALUOP = ALU_AND;  end
          FN_OR:   begin w_ralu = 1'b1; ALUOP = ALU_OR;   end
          FN_XOR:  begin w_ralu = 1'b1; ALUOP = ALU_XOR;  end
          FN_NOR:  begin w_ralu = 1'b1; ALUOP = ALU_NOR;  end
          FN_SLT:  begin w_ralu = 1'b1; ALUOP = ALU_SLT;  end
          FN_SLTU: begin w_ralu = 1'b1; ALUOP = ALU_SLTU; end
          FN_SLL:  begin w_ralu = 1'b1; ALUOP = ALU_SLL; ALUSrc1 = 1'b1; end
          FN_SRL:  begin w_ralu = 1'b1; ALUOP = ALU_SRL; ALUSrc1 = 1'b1; end
          FN_SRA:  begin w_ralu = 1'b1; ALUOP = ALU_SRA; ALUSrc1 = 1'b1; end
          FN_JR:   jr = 1'b1;
          FN_JALR: begin jr = 1'b1; jl = 1'b1; regDst = 1'b1; w_reg_write = 1'b1; end
          default: ;
        endcase
        if (w_ralu) begin
          regDst      = 1'b1;
          w_reg_write = 1'b1;
        end
      end
      OP_ADDIU: begin w_reg_write = 1'b1; ALUSrc2 = 1'b1; siExt = 1'b1; ALUOP = ALU_ADD;  end
      OP_SLTI:  begin w_reg_write = 1'b1; ALUSrc2 = 1'b1; siExt = 1'b1; ALUOP = ALU_SLT;  end
      OP_SLTIU: begin w_reg_write = 1'b1; ALUSrc2 = 1'b1; siExt = 1'b1; ALUOP = ALU_SLTU; end
      OP_ANDI:  begin w_reg_write = 1'b1; ALUSrc2 = 1'b1; ALUOP = ALU_AND; end
      OP_ORI:   begin w_reg_write = 1'b1; ALUSrc2 = 1'b1; ALUOP = ALU_OR;  end
      OP_XORI:  begin w_reg_write = 1'b1; ALUSrc2 = 1'b1; ALUOP = ALU_XOR; end
      OP_LUI:   begin w_reg_write = 1'b1; ALUSrc2 = 1'b1; ALUOP = ALU_LUI; end
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
        w_reg_write = 1'b1;
        regIn       = 1'b1;
        ALUSrc2     = 1'b1;
        siExt       = 1'b1;
        dmExt       = (w_op == OP_LH) || (w_op == OP_LB);
        if ((w_op == OP_LH) || (w_op == OP_LHU))
          hbw = HBW_H;
        else if ((w_op == OP_LB) || (w_op == OP_LBU))
          hbw = HBW_B;
      end
      OP_SW:    begin w_mem_write = 1'b1; ALUSrc2 = 1'b1; siExt = 1'b1; end
      OP_SH:    begin w_mem_write = 1'b1; ALUSrc2 = 1'b1; siExt = 1'b1; hbw = HBW_H; end
      OP_SB:    begin w_mem_write = 1'b1; ALUSrc2 = 1'b1; siExt = 1'b1; hbw = HBW_B; end
      OP_BEQ, OP_BNE: begin branch = 1'b1; siExt = 1'b1; shift2 = 1'b1; end
      OP_J:     j = 1'b1;
      OP_JAL:   begin j = 1'b1; jl = 1'b1; reg31 = 1'b1; w_reg_write = 1'b1; end
      OP_COP0: begin
        if (w_rs == RS_MF) begin
          mfc         = 1'b1;
          w_reg_write = 1'b1;
        end else if (w_rs == RS_MT) begin
          mtc = 1'b1;
        end else if ((w_rs == RS_CO) && (w_funct == FN_ERET)) begin
          eret = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A stalled instruction must not commit architectural state
  assign regWrite = w_reg_write & ~stall;
  assign memWrite = w_mem_write & ~stall;

endmodule

// File: rtl/tnew_m.sv
// rtl/tnew_m.sv - M-stage capture register, control decode and hazard descriptors
module tnew_m
  import tnew_m_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] IR,
  input  logic [31:0] PC8,
  input  logic [31:0] AO,
  input  logic        BranchOP,
  output logic [3:0]  tnew,
  output logic [4:0]  writereg,
  output logic [31:0] writedata,
  output logic        regDst,
  output logic        reg31,
  output logic        siExt,
  output logic        shift2,
  output logic        regWrite,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic        regIn,
  output logic        memWrite,
  output logic        branch,
  output logic        j,
  output logic        jr,
  output logic        jl,
  output logic        dmExt,
  output logic        eret,
  output logic        mtc,
  output logic        mfc,
  output logic [4:0]  ALUOP,
  output logic [1:0]  hbw
);

  logic [31:0] r_ir;
  logic [31:0] r_pc8;
  logic [31:0] r_ao;
  logic        r_tiao;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir   <= 32'd0;
      r_pc8  <= 32'd0;
      r_ao   <= 32'd0;
      r_tiao <= 1'b0;
    end else if (!stall) begin
      r_ir   <= IR;
      r_pc8  <= PC8;
      r_ao   <= AO;
      r_tiao <= BranchOP;
    end
  end

  instr_ctrl_dec u_dec (
    .instr    (r_ir),
    .tiao     (r_tiao),
    .stall    (1'b0),
    .regDst   (regDst),
    .reg31    (reg31),
    .siExt    (siExt),
    .shift2   (shift2),
    .regWrite (regWrite),
    .ALUSrc1  (ALUSrc1),
    .ALUSrc2  (ALUSrc2),
    .regIn    (regIn),
    .memWrite (memWrite),
    .branch   (branch),
    .j        (j),
    .jr       (jr),
    .jl       (jl),
    .dmExt    (dmExt),
    .eret     (eret),
    .mtc      (mtc),
    .mfc      (mfc),
    .ALUOP    (ALUOP),
    .hbw      (hbw)
  );

  assign w_rt = r_ir[20:16];
  assign w_rd = r_ir[15:11];

  // Only loads and mfc0 produce their value a cycle after M
  assign tnew      = (regIn | mfc) ? 4'd1 : 4'd0;
  assign writereg  = !regWrite ? 5'd0 : reg31 ? 5'd31 : regDst ? w_rd : w_rt;
  assign writedata = jl ? r_pc8 : r_ao;

endmodule

// File: tb/tb_tnew_m.sv
// tb/tb_tnew_m.sv - self-checking bench for tnew_m: vector table, corner sequences, random vs model
module tb_tnew_m;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] IR;
  logic [31:0] PC8;
  logic [31:0] AO;
  logic        BranchOP;
  logic [3:0]  tnew;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic        regDst, reg31, siExt, shift2, regWrite, ALUSrc1, ALUSrc2, regIn;
  logic        memWrite, branch, j, jr, jl, dmExt, eret, mtc, mfc;
  logic [4:0]  ALUOP;
  logic [1:0]  hbw;

  tnew_m dut (
    .clk(clk), .reset(reset), .stall(stall), .IR(IR), .PC8(PC8), .AO(AO),
    .BranchOP(BranchOP), .tnew(tnew), .writereg(writereg), .writedata(writedata),
    .regDst(regDst), .reg31(reg31), .siExt(siExt), .shift2(shift2),
    .regWrite(regWrite), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .regIn(regIn),
    .memWrite(memWrite), .branch(branch), .j(j), .jr(jr), .jl(jl), .dmExt(dmExt),
    .eret(eret), .mtc(mtc), .mfc(mfc), .ALUOP(ALUOP), .hbw(hbw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [16:0] C_REGDST   = 17'h1 << 16;
  localparam logic [16:0] C_REG31    = 17'h1 << 15;
  localparam logic [16:0] C_SIEXT    = 17'h1 << 14;
  localparam logic [16:0] C_SHIFT2   = 17'h1 << 13;
  localparam logic [16:0] C_REGWRITE = 17'h1 << 12;
  localparam logic [16:0] C_ALUSRC1  = 17'h1 << 11;
  localparam logic [16:0] C_ALUSRC2  = 17'h1 << 10;
  localparam logic [16:0] C_REGIN    = 17'h1 << 9;
  localparam logic [16:0] C_MEMWRITE = 17'h1 << 8;
  localparam logic [16:0] C_BRANCH   = 17'h1 << 7;
  localparam logic [16:0] C_J        = 17'h1 << 6;
  localparam logic [16:0] C_JR       = 17'h1 << 5;
  localparam logic [16:0] C_JL       = 17'h1 << 4;
  localparam logic [16:0] C_DMEXT    = 17'h1 << 3;
  localparam logic [16:0] C_ERET     = 17'h1 << 2;
  localparam logic [16:0] C_MTC      = 17'h1 << 1;
  localparam logic [16:0] C_MFC      = 17'h1 << 0;

  logic [16:0] d_ctrl;
  assign d_ctrl = {regDst, reg31, siExt, shift2, regWrite, ALUSrc1, ALUSrc2, regIn,
                   memWrite, branch, j, jr, jl, dmExt, eret, mtc, mfc};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_tnew, input logic [4:0] e_wreg,
                         input logic [31:0] e_wdata, input logic [16:0] e_ctrl,
                         input logic [4:0] e_alu, input logic [1:0] e_hbw);
    chk({tag, ".tnew"},      64'(tnew),      64'(e_tnew));
    chk({tag, ".writereg"},  64'(writereg),  64'(e_wreg));
    chk({tag, ".writedata"}, 64'(writedata), 64'(e_wdata));
    chk({tag, ".ctrl"},      64'(d_ctrl),    64'(e_ctrl));
    chk({tag, ".ALUOP"},     64'(ALUOP),     64'(e_alu));
    chk({tag, ".hbw"},       64'(hbw),       64'(e_hbw));
  endtask

  task automatic step(input logic [31:0] ir, input logic [31:0] pc8, input logic [31:0] ao,
                      input logic bop, input logic rst, input logic stl);
    IR = ir; PC8 = pc8; AO = ao; BranchOP = bop; reset = rst; stall = stl;
    @(posedge clk);
    #1;
  endtask

  typedef enum {
    M_NONE, M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU, M_SLL, M_SRL, M_SRA,
    M_JR, M_JALR, M_ADDIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_SLTI, M_SLTIU,
    M_LW, M_LH, M_LHU, M_LB, M_LBU, M_SW, M_SH, M_SB, M_BEQ, M_BNE, M_J, M_JAL,
    M_MFC0, M_MTC0, M_ERET
  } mn_t;

  function automatic mn_t mn_of(input logic [31:0] ir);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    op = ir[31:26]; fn = ir[5:0]; rs = ir[25:21];
    case (op)
      6'h00: case (fn)
        6'h21: return M_ADDU; 6'h23: return M_SUBU; 6'h24: return M_AND;
        6'h25: return M_OR;   6'h26: return M_XOR;  6'h27: return M_NOR;
        6'h2A: return M_SLT;  6'h2B: return M_SLTU; 6'h00: return M_SLL;
        6'h02: return M_SRL;  6'h03: return M_SRA;  6'h08: return M_JR;
        6'h09: return M_JALR;
        default: return M_NONE;
      endcase
      6'h09: return M_ADDIU; 6'h0C: return M_ANDI; 6'h0D: return M_ORI;
      6'h0E: return M_XORI;  6'h0F: return M_LUI;  6'h0A: return M_SLTI;
      6'h0B: return M_SLTIU; 6'h23: return M_LW;   6'h21: return M_LH;
      6'h25: return M_LHU;   6'h20: return M_LB;   6'h24: return M_LBU;
      6'h2B: return M_SW;    6'h29: return M_SH;   6'h28: return M_SB;
      6'h04: return M_BEQ;   6'h05: return M_BNE;  6'h02: return M_J;
      6'h03: return M_JAL;
      6'h10: begin
        if (rs == 5'h00) return M_MFC0;
        if (rs == 5'h04) return M_MTC0;
        if (rs == 5'h10 && fn == 6'h18) return M_ERET;
        return M_NONE;
      end
      default: return M_NONE;
    endcase
  endfunction

  task automatic model(input logic [31:0] ir, input logic [31:0] pc8, input logic [31:0] ao,
                       output logic [3:0] e_tnew, output logic [4:0] e_wreg,
                       output logic [31:0] e_wdata, output logic [16:0] e_ctrl,
                       output logic [4:0] e_alu, output logic [1:0] e_hbw);
    mn_t mn;
    bit ralu, sh, ialu, ld, st, writes, link;
    mn     = mn_of(ir);
    ralu   = mn inside {M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU, M_SLL, M_SRL, M_SRA};
    sh     = mn inside {M_SLL, M_SRL, M_SRA};
    ialu   = mn inside {M_ADDIU, M_ANDI, M_ORI, M_XORI, M_SLTI, M_SLTIU};
    ld     = mn inside {M_LW, M_LH, M_LHU, M_LB, M_LBU};
    st     = mn inside {M_SW, M_SH, M_SB};
    link   = mn inside {M_JAL, M_JALR};
    writes = ralu || ialu || ld || link || mn == M_LUI || mn == M_MFC0;
    e_ctrl = 17'd0;
    if (ralu || mn == M_JALR) e_ctrl |= C_REGDST;
    if (mn == M_JAL) e_ctrl |= C_REG31;
    if (mn inside {M_ADDIU, M_SLTI, M_SLTIU, M_BEQ, M_BNE} || ld || st) e_ctrl |= C_SIEXT;
    if (mn inside {M_BEQ, M_BNE}) e_ctrl |= C_SHIFT2 | C_BRANCH;
    if (writes) e_ctrl |= C_REGWRITE;
    if (sh) e_ctrl |= C_ALUSRC1;
    if (ialu || ld || st || mn == M_LUI) e_ctrl |= C_ALUSRC2;
    if (ld) e_ctrl |= C_REGIN;
    if (st) e_ctrl |= C_MEMWRITE;
    if (mn inside {M_J, M_JAL}) e_ctrl |= C_J;
    if (mn inside {M_JR, M_JALR}) e_ctrl |= C_JR;
    if (link) e_ctrl |= C_JL;
    if (mn inside {M_LH, M_LB}) e_ctrl |= C_DMEXT;
    if (mn == M_ERET) e_ctrl |= C_ERET;
    if (mn == M_MTC0) e_ctrl |= C_MTC;
    if (mn == M_MFC0) e_ctrl |= C_MFC;
    case (mn)
      M_SUBU:          e_alu = 5'd1;
      M_AND, M_ANDI:   e_alu = 5'd2;
      M_OR, M_ORI:     e_alu = 5'd3;
      M_XOR, M_XORI:   e_alu = 5'd4;
      M_NOR:           e_alu = 5'd5;
      M_SLT, M_SLTI:   e_alu = 5'd6;
      M_SLTU, M_SLTIU: e_alu = 5'd7;
      M_SLL:           e_alu = 5'd8;
      M_SRL:           e_alu = 5'd9;
      M_SRA:           e_alu = 5'd10;
      M_LUI:           e_alu = 5'd11;
      default:         e_alu = 5'd0;
    endcase
    if (mn inside {M_LH, M_LHU, M_SH}) e_hbw = 2'd1;
    else if (mn inside {M_LB, M_LBU, M_SB}) e_hbw = 2'd2;
    else e_hbw = 2'd0;
    if (!writes) e_wreg = 5'd0;
    else if (mn == M_JAL) e_wreg = 5'd31;
    else if (ralu || mn == M_JALR) e_wreg = ir[15:11];
    else e_wreg = ir[20:16];
    e_tnew  = (ld || mn == M_MFC0) ? 4'd1 : 4'd0;
    e_wdata = link ? pc8 : ao;
  endtask

  typedef struct {
    string       nm;
    logic [31:0] ir;
    logic [31:0] pc8;
    logic [31:0] ao;
    logic [3:0]  tnew;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [16:0] ctrl;
    logic [4:0]  alu;
    logic [1:0]  hbw;
  } vec_t;

  vec_t vecs[12];

  localparam logic [31:0] I_ADDU = 32'h00221821;
  localparam logic [31:0] I_SW   = 32'hACA40008;
  localparam logic [31:0] I_LW   = 32'h8D280004;
  localparam logic [16:0] NOP_CTRL = C_REGDST | C_REGWRITE | C_ALUSRC1;

  logic [31:0] q_mask[$];
  logic [31:0] q_val[$];
  logic [31:0] m_ir, m_pc8, m_ao;
  logic [3:0]  e_tnew;
  logic [4:0]  e_wreg;
  logic [31:0] e_wdata;
  logic [16:0] e_ctrl;
  logic [4:0]  e_alu;
  logic [1:0]  e_hbw;

  initial begin
    vecs[0]  = '{"lw",    I_LW,         32'h0,    32'h100, 4'd1, 5'd8,  32'h100,
                 C_SIEXT | C_REGWRITE | C_ALUSRC2 | C_REGIN, 5'd0, 2'd0};
    vecs[1]  = '{"jal",   32'h0C000100, 32'h3008, 32'h999, 4'd0, 5'd31, 32'h3008,
                 C_REG31 | C_REGWRITE | C_J | C_JL, 5'd0, 2'd0};
    vecs[2]  = '{"lb",    32'h80240000, 32'h10,   32'h204, 4'd1, 5'd4,  32'h204,
                 C_SIEXT | C_REGWRITE | C_ALUSRC2 | C_REGIN | C_DMEXT, 5'd0, 2'd2};
    vecs[3]  = '{"lhu",   32'h94260002, 32'h14,   32'h206, 4'd1, 5'd6,  32'h206,
                 C_SIEXT | C_REGWRITE | C_ALUSRC2 | C_REGIN, 5'd0, 2'd1};
    vecs[4]  = '{"mfc0",  32'h40056000, 32'h18,   32'h1234, 4'd1, 5'd5, 32'h1234,
                 C_REGWRITE | C_MFC, 5'd0, 2'd0};
    vecs[5]  = '{"undef", 32'hFC000000, 32'h1C,   32'hABCD, 4'd0, 5'd0, 32'hABCD,
                 17'd0, 5'd0, 2'd0};
    vecs[6]  = '{"beq",   32'h10220005, 32'h20,   32'h0,   4'd0, 5'd0,  32'h0,
                 C_SIEXT | C_SHIFT2 | C_BRANCH, 5'd0, 2'd0};
    vecs[7]  = '{"ori",   32'h3467FFFF, 32'h24,   32'hFFFF, 4'd0, 5'd7, 32'hFFFF,
                 C_REGWRITE | C_ALUSRC2, 5'd3, 2'd0};
    vecs[8]  = '{"jalr",  32'h00601009, 32'h4040, 32'h77,  4'd0, 5'd2,  32'h4040,
                 C_REGDST | C_REGWRITE | C_JR | C_JL, 5'd0, 2'd0};
    vecs[9]  = '{"eret",  32'h42000018, 32'h2C,   32'h5,   4'd0, 5'd0,  32'h5,
                 C_ERET, 5'd0, 2'd0};
    vecs[10] = '{"lui",   32'h3C091234, 32'h30,   32'h12340000, 4'd0, 5'd9, 32'h12340000,
                 C_REGWRITE | C_ALUSRC2, 5'd11, 2'd0};
    vecs[11] = '{"sra",   32'h000520C3, 32'h34,   32'hFFFF0000, 4'd0, 5'd4, 32'hFFFF0000,
                 C_REGDST | C_REGWRITE | C_ALUSRC1, 5'd10, 2'd0};

    // Reset from arbitrary inputs yields the all-zero instruction (sll $0)
    step(32'hDEADBEEF, 32'h1111, 32'h2222, 1'b1, 1'b1, 1'b0);
    chk_all("reset", 4'd0, 5'd0, 32'h0, NOP_CTRL, 5'd8, 2'd0);

    foreach (vecs[i]) begin
      step(vecs[i].ir, vecs[i].pc8, vecs[i].ao, 1'b0, 1'b0, 1'b0);
      chk_all(vecs[i].nm, vecs[i].tnew, vecs[i].wreg, vecs[i].wdata, vecs[i].ctrl,
              vecs[i].alu, vecs[i].hbw);
    end

    // Stall holds addu while sw waits at the input
    step(I_ADDU, 32'h40, 32'h55, 1'b0, 1'b0, 1'b0);
    chk_all("addu", 4'd0, 5'd3, 32'h55, C_REGDST | C_REGWRITE, 5'd0, 2'd0);
    step(I_SW, 32'h44, 32'h77, 1'b0, 1'b0, 1'b1);
    chk_all("stall1", 4'd0, 5'd3, 32'h55, C_REGDST | C_REGWRITE, 5'd0, 2'd0);
    step(I_SW, 32'h44, 32'h77, 1'b0, 1'b0, 1'b1);
    chk_all("stall2", 4'd0, 5'd3, 32'h55, C_REGDST | C_REGWRITE, 5'd0, 2'd0);
    step(I_SW, 32'h44, 32'h77, 1'b0, 1'b0, 1'b0);
    chk_all("sw", 4'd0, 5'd0, 32'h77, C_SIEXT | C_ALUSRC2 | C_MEMWRITE, 5'd0, 2'd0);

    // Reset wins over stall
    step(I_LW, 32'h48, 32'h88, 1'b0, 1'b0, 1'b0);
    step(32'h0C000100, 32'h3008, 32'h99, 1'b1, 1'b1, 1'b1);
    chk_all("rst_over_stall", 4'd0, 5'd0, 32'h0, NOP_CTRL, 5'd8, 2'd0);

    foreach (vecs[i]) begin
      q_mask.push_back(32'hFC000000);
      q_val.push_back({vecs[i].ir[31:26], 26'd0});
    end
    begin
      logic [5:0] fns[13];
      logic [5:0] ops[19];
      fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09};
      ops = '{6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h0A, 6'h0B, 6'h23, 6'h21, 6'h25,
              6'h20, 6'h24, 6'h2B, 6'h29, 6'h28, 6'h04, 6'h05, 6'h02, 6'h03};
      foreach (fns[i]) begin q_mask.push_back(32'hFC00003F); q_val.push_back({26'd0, fns[i]}); end
      foreach (ops[i]) begin q_mask.push_back(32'hFC000000); q_val.push_back({ops[i], 26'd0}); end
    end
    q_mask.push_back(32'hFFE00000); q_val.push_back(32'h40000000);
    q_mask.push_back(32'hFFE00000); q_val.push_back(32'h40800000);
    q_mask.push_back(32'hFFFFFFFF); q_val.push_back(32'h42000018);
    q_mask.push_back(32'h0);        q_val.push_back(32'h0);
    q_mask.push_back(32'h0);        q_val.push_back(32'h0);

    m_ir = 32'd0; m_pc8 = 32'd0; m_ao = 32'd0;
    step(32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 800; n++) begin
      int k;
      logic [31:0] ir, pc8, ao;
      logic rst, stl;
      k   = $urandom_range(0, q_mask.size() - 1);
      ir  = ($urandom & ~q_mask[k]) | q_val[k];
      pc8 = $urandom;
      ao  = $urandom;
      rst = ($urandom_range(0, 19) == 0);
      stl = ($urandom_range(0, 4) == 0);
      step(ir, pc8, ao, 1'($urandom_range(0, 1)), rst, stl);
      if (rst) begin
        m_ir = 32'd0; m_pc8 = 32'd0; m_ao = 32'd0;
      end else if (!stl) begin
        m_ir = ir; m_pc8 = pc8; m_ao = ao;
      end
      model(m_ir, m_pc8, m_ao, e_tnew, e_wreg, e_wdata, e_ctrl, e_alu, e_hbw);
      chk_all($sformatf("rand%0d", n), e_tnew, e_wreg, e_wdata, e_ctrl, e_alu, e_hbw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
